// File: rtl/tx_burst_sequencer.sv
// TX burst power sequencer: wakes the DAC, settles the PA, streams one framed
// burst from upstream to the DAC chain, drains the interpolators and powers down.
module tx_burst_sequencer #(
  parameter int unsigned WAKE_CYCLES      = 200,
  parameter int unsigned PA_SETTLE_CYCLES = 1000,
  parameter int unsigned DRAIN_CYCLES     = 2000,
  parameter logic [3:0]  DAC_CTRL_ON      = 4'b0011
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic [15:0] frame_len,
  input  logic        abort,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [3:0]  m_axis_tkeep,
  input  logic        m_axis_tready,
  output logic [3:0]  dac_control,
  output logic        dac_sleep,
  output logic        pa_enable,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        aborted
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAKE      = 3'd1,
    S_PA_SETTLE = 3'd2,
    S_STREAM    = 3'd3,
    S_DRAIN     = 3'd4,
    S_POWERDOWN = 3'd5
  } state_t;

  // Timer is loaded with N-1 on entry so each phase lasts exactly N cycles.
  localparam logic [15:0] WAKE_LD   = 16'(WAKE_CYCLES - 1);
  localparam logic [15:0] SETTLE_LD = 16'(PA_SETTLE_CYCLES - 1);
  localparam logic [15:0] DRAIN_LD  = 16'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] count_q, count_d;
  logic [15:0] len_q, len_d;
  logic        underrun_q, underrun_d;
  logic        aborted_q, aborted_d;
  logic        done_q, done_d;

  logic        in_stream_s;
  logic        hs_s;
  logic        last_s;
  logic        timer_zero_s;

  assign in_stream_s  = (state_q == S_STREAM);
  assign hs_s         = in_stream_s && s_axis_tvalid && m_axis_tready;
  assign last_s       = in_stream_s && (count_q == (len_q - 16'd1));
  assign timer_zero_s = (timer_q == 16'd0);

  // State register and sticky status flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      count_q    <= 16'd0;
      len_q      <= 16'd0;
      underrun_q <= 1'b0;
      aborted_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      len_q      <= len_d;
      underrun_q <= underrun_d;
      aborted_q  <= aborted_d;
      done_q     <= done_d;
    end
  end

  // Next-state, timer, counter and flag logic
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    count_d    = count_q;
    len_d      = len_q;
    underrun_d = underrun_q;
    aborted_d  = aborted_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (frame_len != 16'd0)) begin
          state_d    = S_WAKE;
          timer_d    = WAKE_LD;
          count_d    = 16'd0;
          len_d      = frame_len;
          underrun_d = 1'b0;
          aborted_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAKE: begin
        if (abort) begin
          state_d   = S_POWERDOWN;
          timer_d   = WAKE_LD;
          aborted_d = 1'b1;
        end else if (timer_zero_s) begin
          state_d = S_PA_SETTLE;
          timer_d = SETTLE_LD;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_PA_SETTLE: begin
        if (abort) begin
          state_d   = S_POWERDOWN;
          timer_d   = WAKE_LD;
          aborted_d = 1'b1;
        end else if (timer_zero_s) begin
          state_d = S_STREAM;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STREAM: begin
        if (hs_s) begin
          count_d = count_q + 16'd1;
        end else begin
          count_d = count_q;
        end
        if (m_axis_tready && !s_axis_tvalid) begin
          underrun_d = 1'b1;
        end else begin
          underrun_d = underrun_q;
        end
        // Abort wins over end-of-frame; a coincident sample still transfers.
        if (abort) begin
          state_d   = S_POWERDOWN;
          timer_d   = WAKE_LD;
          aborted_d = 1'b1;
        end else if (hs_s && last_s) begin
          state_d = S_DRAIN;
          timer_d = DRAIN_LD;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d   = S_POWERDOWN;
          timer_d   = WAKE_LD;
          aborted_d = 1'b1;
        end else if (timer_zero_s) begin
          state_d = S_POWERDOWN;
          timer_d = WAKE_LD;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_POWERDOWN: begin
        if (timer_zero_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 16'd0;
      end
    endcase
  end

  // Power-control outputs decoded from the registered state
  always_comb begin
    dac_control = 4'd0;
    dac_sleep   = 1'b1;
    pa_enable   = 1'b0;
    case (state_q)
      S_IDLE: begin
        dac_control = 4'd0;
        dac_sleep   = 1'b1;
        pa_enable   = 1'b0;
      end
      S_WAKE: begin
        dac_control = 4'd0;
        dac_sleep   = 1'b0;
        pa_enable   = 1'b0;
      end
      S_PA_SETTLE, S_STREAM, S_DRAIN: begin
        dac_control = DAC_CTRL_ON;
        dac_sleep   = 1'b0;
        pa_enable   = 1'b1;
      end
      S_POWERDOWN: begin
        dac_control = DAC_CTRL_ON;
        dac_sleep   = 1'b0;
        pa_enable   = 1'b0;
      end
      default: begin
        dac_control = 4'd0;
        dac_sleep   = 1'b1;
        pa_enable   = 1'b0;
      end
    endcase
  end

  assign m_axis_tdata  = in_stream_s ? s_axis_tdata : 32'd0;
  assign m_axis_tvalid = in_stream_s && s_axis_tvalid;
  assign m_axis_tlast  = last_s;
  assign m_axis_tkeep  = 4'hF;
  assign s_axis_tready = in_stream_s && m_axis_tready;

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign underrun = underrun_q;
  assign aborted  = aborted_q;

endmodule

// File: doc/tx_burst_sequencer.md
TX_BURST_SEQUENCER -- requirements
Module: tx_burst_sequencer

Interface
REQ-001 Parameter WAKE_CYCLES, 200: cycles DAC held awake before PA enable; also PA-off to DAC-sleep gap; range 1..65535.
REQ-002 Parameter PA_SETTLE_CYCLES, 1000: cycles PA is on before first sample is accepted; range 1..65535.
REQ-003 Parameter DRAIN_CYCLES, 2000: cycles after last sample for the interpolation chain to flush; range 1..65535.
REQ-004 Parameter DAC_CTRL_ON, 4'b0011: value driven on dac_control while the DAC is active.
REQ-005 aclk  in  1  single clock for all logic; reset is synchronous and active-high.
REQ-006 areset  in  1  synchronous active-high reset.
REQ-007 start  in  1  burst request, sampled in IDLE only.
REQ-008 frame_len  in  16  samples per burst, latched on accepted start.
REQ-009 abort  in  1  terminate current burst.
REQ-010 s_axis_tdata/tvalid  in  32/1  upstream IQ samples {Q[31:16],I[15:0]}; s_axis_tready  out  1.
REQ-011 m_axis_tdata/tvalid/tlast  out  32/1/1; m_axis_tkeep  out  4, constant 4'hF; m_axis_tready  in  1; drives the DAC chain S_AXIS.
REQ-012 dac_control  out  4; dac_sleep  out  1; pa_enable  out  1.
REQ-013 busy  out  1 (state != IDLE); done  out  1 (one-cycle pulse); underrun  out  1; aborted  out  1.

Function
REQ-014 States: IDLE, WAKE, PA_SETTLE, STREAM, DRAIN, POWERDOWN; a single 16-bit down-timer and a 16-bit sample counter.
REQ-015 IDLE: start=1 with frame_len!=0 latches frame_len, clears underrun/aborted, and enters WAKE next cycle; start with frame_len=0 is ignored.
REQ-016 WAKE: dac_sleep=0, dac_control=0, pa_enable=0; lasts exactly WAKE_CYCLES cycles, then PA_SETTLE.
REQ-017 PA_SETTLE: dac_control=DAC_CTRL_ON, pa_enable=1; lasts exactly PA_SETTLE_CYCLES cycles, then STREAM.
REQ-018 STREAM: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready (combinational, zero latency); outside STREAM, m_axis_tvalid=0 and s_axis_tready=0.
REQ-019 Sample counter increments on each m_axis handshake; m_axis_tlast=1 when counter==latched frame_len-1; the handshake carrying tlast moves to DRAIN next cycle.
REQ-020 underrun sets (sticky until next accepted start) on any STREAM cycle with m_axis_tready=1 and s_axis_tvalid=0.
REQ-021 DRAIN: dac_control=DAC_CTRL_ON, pa_enable=1, no transfers; lasts DRAIN_CYCLES, then POWERDOWN.
REQ-022 POWERDOWN: pa_enable=0, dac_control=DAC_CTRL_ON, dac_sleep=0; lasts WAKE_CYCLES, then IDLE.
REQ-023 IDLE outputs: dac_control=0, dac_sleep=1, pa_enable=0, busy=0; done=1 in the first IDLE cycle after POWERDOWN only.
REQ-024 abort=1 in WAKE, PA_SETTLE, STREAM or DRAIN enters POWERDOWN next cycle and sets aborted (sticky until next start); abort ignored in IDLE and POWERDOWN; done still pulses.
REQ-025 abort coincident with a STREAM handshake: that sample transfers, then POWERDOWN; tlast is never emitted on an aborted burst except when abort coincides with the tlast handshake.
REQ-026 start while busy is ignored; start and abort together in IDLE: start accepted.

Reset
REQ-027 areset=1 at a rising aclk edge forces IDLE from any state: dac_control=0, dac_sleep=1, pa_enable=0, m_axis_tvalid=0, s_axis_tready=0, tlast=0, busy=0, done=0, underrun=0, aborted=0, counters=0.
REQ-028 Reset mid-burst drops PA and DAC immediately (no POWERDOWN sequencing) and emits no done pulse.

Verification (WAKE_CYCLES=4, PA_SETTLE_CYCLES=8, DRAIN_CYCLES=6)
REQ-029 start at cycle 0, frame_len=3, tvalid/tready always 1 -> dac_sleep=0 cycles 1-25, pa_enable=1 cycles 5-21, handshakes cycles 13-15, tlast at 15, done=1 at 26, underrun=0.
REQ-030 frame_len=4, m_axis_tready toggled 1/0 each cycle -> exactly 4 handshakes, tlast only on the 4th, all data passed in order unmodified.
REQ-031 s_axis_tvalid=0 for 2 cycles mid-STREAM with tready=1 -> underrun=1 held through done; cleared on next start.
REQ-032 abort in cycle 14 of REQ-029 stimulus -> sample at 14 transfers, no tlast, pa_enable=0 from 15, IDLE/done at 19, aborted=1.
REQ-033 areset during DRAIN -> next cycle IDLE outputs per REQ-027, done=0; start with frame_len=0 -> remains IDLE.
